// File: rtl/luna_pkg.sv
// luna_pkg: shared fetch constants and types; LUNA_FETCH_PREFETCH_EN selects the two-entry buffer.
package luna_pkg;
    localparam int ADDR_W = 15;
    localparam logic [ADDR_W-1:0] RESET_PC = '0;
`ifdef LUNA_FETCH_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {S_FETCH, S_STALL, S_DISCARD} fetch_state_t;

    typedef struct packed {
        logic [15:0]       word;
        logic [ADDR_W-1:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: shift-style FIFO of fetch entries; flush beats push and pop.
module fetch_buffer #(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         push,
    input  logic                         pop,
    input  luna_pkg::fetch_entry_t       wdata,
    output luna_pkg::fetch_entry_t       head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          do_pop;
    logic [CW-1:0] wr;

    assign do_pop = pop & (count != '0);
    assign wr     = count - CW'(do_pop);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) count <= '0;
        else        count <= flush ? '0 : count + CW'(push) - CW'(do_pop);

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        luna_pkg::fetch_entry_t q, nxt;
        if (g < DEPTH - 1) begin : g_sh
            assign nxt = g_ent[g+1].q;
        end else begin : g_tail
            assign nxt = q;
        end
        // a push lands behind whatever survives this cycle's pop
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n)                              q <= '0;
            else if (!flush && push && wr == CW'(g)) q <= wdata;
            else if (!flush && do_pop)               q <= nxt;
    end

    assign head = g_ent[0].q;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: Luna PC, imem req/ack fetch and redirect/discard FSM; LUNA_FETCH_PREFETCH_EN adds a prefetch slot.
module instr_fetch_unit #(
    parameter int                ADDR_W   = luna_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = luna_pkg::RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_rdata,
    output logic [15:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              set_pc,
    input  logic [15:0]       jump_target
);
    import luna_pkg::*;

    fetch_state_t      state, state_d;
    logic [ADDR_W-1:0] fetch_pc, pc_d, redirect_pc, rpc_d, target;
    logic              started, ack, push, pop, full_after, unused_bits;
    logic [CNT_W-1:0]  count;
    fetch_entry_t      head, wdata;

    assign target      = jump_target[ADDR_W-1:0];
    assign unused_bits = ^jump_target[15:ADDR_W];
    assign imem_req    = started & (state != S_STALL);
    assign imem_addr   = fetch_pc;
    assign ack         = imem_ack & imem_req;
    assign instr_valid = count != '0;
    assign pop         = instr_valid & instr_ready & ~set_pc;
    assign push        = ack & (state == S_FETCH) & ~set_pc;
    assign full_after  = count == CNT_W'(DEPTH - 1);
    assign wdata       = '{word: imem_rdata, pc: fetch_pc};
    assign instr       = head.word;
    assign instr_pc    = head.pc;

    always_comb begin
        state_d = state;
        pc_d    = fetch_pc;
        rpc_d   = redirect_pc;
        if (set_pc) begin
            // an unacked request pins imem_addr, so park the target until its ack
            if (imem_req & ~ack) begin
                state_d = S_DISCARD;
                rpc_d   = target;
            end else begin
                state_d = S_FETCH;
                pc_d    = target;
            end
        end else if (state == S_DISCARD) begin
            if (ack) begin
                state_d = S_FETCH;
                pc_d    = redirect_pc;
            end
        end else if (state == S_STALL) begin
            if (pop) state_d = S_FETCH;
        end else if (ack) begin
            pc_d    = fetch_pc + ADDR_W'(1);
            state_d = (full_after & ~pop) ? S_STALL : S_FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state       <= S_FETCH;
            started     <= 1'b0;
            fetch_pc    <= RESET_PC;
            redirect_pc <= '0;
        end else begin
            state       <= state_d;
            started     <= 1'b1;
            fetch_pc    <= pc_d;
            redirect_pc <= rpc_d;
        end

    fetch_buffer #(.DEPTH(DEPTH)) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (set_pc),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .head  (head),
        .count (count)
    );
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed stimulus against a stream model and a latency-programmable memory.
module tb_instr_fetch_unit;
`ifdef LUNA_FETCH_PREFETCH_EN
    localparam int BUF = 2;
`else
    localparam int BUF = 1;
`endif

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        imem_req, imem_ack, instr_valid, instr_ready, set_pc;
    logic [14:0] imem_addr, instr_pc;
    logic [15:0] imem_rdata, instr, jump_target;
    logic        imem_req1, instr_valid1;
    logic [14:0] imem_addr1, instr_pc1;
    logic [15:0] instr1;
    logic        ready1 = 1'b1, set1 = 1'b0;
    logic [15:0] jt1 = 16'h0000;
    int          lat = 0, wcnt, tests = 0, fails = 0, wn = 0, n;
    logic        found;
    logic [14:0] wrap_addr [4];
    logic [14:0] wrap_exp  [4] = '{15'h7FFE, 15'h7FFF, 15'h0000, 15'h0001};

    always #5 clk = ~clk;

    function automatic logic [15:0] word_at(input logic [14:0] a);
        return {a[6:0], 1'b1, a[14:7]} ^ 16'hC3A5;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    assign imem_ack   = imem_req && (wcnt >= lat);
    assign imem_rdata = imem_ack ? word_at(imem_addr) : 16'hDEAD;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) wcnt <= 0;
        else        wcnt <= (imem_req && !imem_ack) ? wcnt + 1 : 0;

    instr_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .set_pc(set_pc),
        .jump_target(jump_target)
    );

    instr_fetch_unit #(.RESET_PC(15'h7FFE)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req1), .imem_addr(imem_addr1),
        .imem_ack(imem_req1), .imem_rdata(word_at(imem_addr1)), .instr(instr1),
        .instr_pc(instr_pc1), .instr_valid(instr_valid1), .instr_ready(ready1),
        .set_pc(set1), .jump_target(jt1)
    );

    always @(negedge clk)
        if (rst_n && imem_req1 && wn < 4) begin
            wrap_addr[wn] = imem_addr1;
            wn++;
        end

    // stream model: presented words run sequentially from reset or the last redirect
    logic        pend, vnr;
    logic [14:0] p_addr, p_ipc, exp_pc;
    logic [15:0] p_instr;
    always @(negedge clk) begin
        if (!rst_n) begin
            pend = 1'b0; vnr = 1'b0; exp_pc = 15'h0000;
        end else begin
            if (pend) begin
                check("req_held", imem_req, 1);
                check("addr_stable", imem_addr, p_addr);
            end
            if (vnr) begin
                check("valid_held", instr_valid, 1);
                check("instr_held", instr, p_instr);
                check("pc_held", instr_pc, p_ipc);
            end
            if (instr_valid) begin
                check("stream_pc", instr_pc, exp_pc);
                check("stream_word", instr, word_at(instr_pc));
            end
            if (set_pc) exp_pc = jump_target[14:0];
            else if (instr_valid && instr_ready) exp_pc = exp_pc + 15'd1;
            pend = imem_req && !imem_ack; p_addr = imem_addr;
            vnr = instr_valid && !instr_ready && !set_pc; p_instr = instr; p_ipc = instr_pc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input logic want5, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = imem_req && wcnt == 0 && (!want5 || imem_addr == 15'h0005);
        end
    endtask

    initial begin
        instr_ready = 1'b1; set_pc = 1'b0; jump_target = 16'h0000;
        repeat (2) tick();
        check("rst_req", imem_req, 0);
        check("rst_addr", imem_addr, 15'h0000);
        check("rst_instr", instr, 16'h0000);
        check("rst_pc", instr_pc, 15'h0000);
        check("rst_valid", instr_valid, 0);
        check("rst_addr_wrap", imem_addr1, 15'h7FFE);
        rst_n = 1'b1;
        tick();
        check("req_rise", imem_req, 1);
        check("valid_late", instr_valid, 0);
        tick();
        check("first_valid", instr_valid, 1);
        check("first_pc", instr_pc, 15'h0000);
        check("first_word", instr, 16'hC2A5);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (instr_valid) n++;
        end
        tick();
        check("throughput", n, (BUF == 2) ? 8 : 4);
        for (int i = 0; i < 4; i++) check("wrap_addr", wrap_addr[i], wrap_exp[i]);

        instr_ready = 1'b0;
        repeat (10) tick();
        check("bp_req_low", imem_req, 0);
        check("bp_valid", instr_valid, 1);
        set_pc = 1'b1; jump_target = 16'h0040;
        tick();
        set_pc = 1'b0;
        check("redir_req", imem_req, 1);
        check("redir_addr", imem_addr, 15'h0040);
        tick();
        check("redir_valid", instr_valid, 1);
        check("redir_pc", instr_pc, 15'h0040);
        check("redir_word", instr, 16'h42A5);
        instr_ready = 1'b1;
        repeat (6) tick();

        rst_n = 1'b0; instr_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (imem_ack) n++;
        end
        tick();
        check("fill_acks", n, BUF);
        check("fill_req_low", imem_req, 0);
        check("fill_pc", instr_pc, 15'h0000);
        instr_ready = 1'b1;
        repeat (10) tick();

        rst_n = 1'b0; lat = 2;
        tick();
        rst_n = 1'b1;
        wait_start(1'b1, found);
        check("reach_req5", found, 1);
        tick();
        set_pc = 1'b1; jump_target = 16'h0123;
        tick();
        set_pc = 1'b0;
        check("infl_req", imem_req, 1);
        check("infl_addr", imem_addr, 15'h0005);
        @(negedge clk);
        check("infl_ack", imem_ack, 1);
        tick();
        check("infl_next", imem_addr, 15'h0123);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            found = instr_valid;
        end
        check("infl_valid", found, 1);
        check("infl_pc", instr_pc, 15'h0123);
        tick();

        wait_start(1'b0, found);
        check("reach_req", found, 1);
        tick();
        set_pc = 1'b1; jump_target = 16'h0300;
        tick();
        jump_target = 16'h0310;
        tick();
        set_pc = 1'b0;
        check("last_wins", imem_addr, 15'h0310);
        repeat (8) tick();

        wait_start(1'b0, found);
        check("reach_req2", found, 1);
        tick();
        set_pc = 1'b1; jump_target = 16'h0050;
        tick();
        set_pc = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("arst_req", imem_req, 0);
        check("arst_addr", imem_addr, 15'h0000);
        check("arst_valid", instr_valid, 0);
        check("arst_instr", instr, 16'h0000);
        check("arst_pc", instr_pc, 15'h0000);
        lat = 0;
        tick();
        rst_n = 1'b1;
        tick();
        check("restart_req", imem_req, 1);
        check("restart_addr", imem_addr, 15'h0000);
        tick();
        check("restart_valid", instr_valid, 1);
        check("restart_pc", instr_pc, 15'h0000);
        repeat (6) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
